mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM latch.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_req_fsm.sv | 65 ++++++
 rtl/mem_access_stage.sv | 86 ++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared widths, datapath types and MEM-stage state encoding
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_AW-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HALTED
  } mem_state_t;
endpackage

// File: rtl/mem_req_fsm.sv
// rtl/mem_req_fsm.sv - dcache request sequencing, stall and commit decode for the MEM stage
module mem_req_fsm
  import cpu_types_pkg::*;
(
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_in_valid,
  input  logic i_ren,
  input  logic i_wen,
  input  logic i_halt,
  input  logic i_dhit,
  output logic o_ren,
  output logic o_wen,
  output logic o_stall,
  output logic o_commit,
  output logic o_halted
);
  mem_state_t r_state;
  mem_state_t w_next;
  logic       w_mem_op;

  assign w_mem_op = i_in_valid & (i_ren | i_wen);
  assign o_halted = (r_state == HALTED);

  always_comb begin
    w_next   = r_state;
    o_ren    = 1'b0;
    o_wen    = 1'b0;
    o_stall  = 1'b0;
    o_commit = 1'b0;
    // Reset low masks the request so an access in flight is dropped immediately.
    if (i_nrst) begin
      case (r_state)
        IDLE, WAIT: begin
          if (w_mem_op) begin
            o_wen = i_wen;
            o_ren = i_ren & ~i_wen;
            if (i_dhit) begin
              o_commit = 1'b1;
              w_next   = i_halt ? HALTED : IDLE;
            end else begin
              o_stall = 1'b1;
              w_next  = WAIT;
            end
          end else if (i_in_valid) begin
            o_commit = 1'b1;
            w_next   = i_halt ? HALTED : IDLE;
          end else begin
            w_next = IDLE;
          end
        end
        HALTED:  w_next = HALTED;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  a_ren_wen_exclusive: assert property (@(posedge i_clk) disable iff (!i_nrst)
    !((r_state != HALTED) && i_in_valid && i_ren && i_wen));
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: dcache access, stall, MEM/WB register, halt and stall counter
module mem_access_stage
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  input  word_t            pcplus4_in,
  input  word_t            aluOut_in,
  input  word_t            rdat2_in,
  input  regbits_t         wsel_in,
  input  logic             MemToReg_in,
  input  logic             JType_in,
  input  logic             regWEN_in,
  input  logic             dMemREN_in,
  input  logic             dMemWEN_in,
  input  logic             Halt_in,
  input  logic             dhit,
  input  word_t            dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  output logic             mem_stall,
  output logic             wb_valid,
  output regbits_t         wb_wsel,
  output word_t            wb_wdat,
  output logic             wb_WEN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);
  logic             w_commit;
  word_t            w_wdat;
  logic             r_wb_valid;
  regbits_t         r_wb_wsel;
  word_t            r_wb_wdat;
  logic             r_wb_wen;
  logic [CNT_W-1:0] r_stall_cnt;

  mem_req_fsm u_fsm (
    .i_clk      (CLK),
    .i_nrst     (nRST),
    .i_in_valid (in_valid),
    .i_ren      (dMemREN_in),
    .i_wen      (dMemWEN_in),
    .i_halt     (Halt_in),
    .i_dhit     (dhit),
    .o_ren      (dmemREN),
    .o_wen      (dmemWEN),
    .o_stall    (mem_stall),
    .o_commit   (w_commit),
    .o_halted   (halt)
  );

  assign dmemaddr  = aluOut_in;
  assign dmemstore = rdat2_in;
  assign w_wdat    = MemToReg_in ? dmemload : (JType_in ? pcplus4_in : aluOut_in);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wb_valid <= 1'b0;
      r_wb_wsel  <= '0;
      r_wb_wdat  <= '0;
      r_wb_wen   <= 1'b0;
    end else begin
      r_wb_valid <= w_commit;
      r_wb_wen   <= w_commit & regWEN_in & in_valid;
      if (w_commit) begin
        r_wb_wsel <= wsel_in;
        r_wb_wdat <= w_wdat;
      end
    end
  end

  // Saturates rather than wraps so long stalls stay visible as all-ones.
  always_ff @(posedge CLK) begin
    if (!nRST)                                r_stall_cnt <= '0;
    else if (mem_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign wb_valid     = r_wb_valid;
  assign wb_wsel      = r_wb_wsel;
  assign wb_wdat      = r_wb_wdat;
  assign wb_WEN       = r_wb_wen;
  assign stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST, in_valid, MemToReg_in, JType_in, regWEN_in, dMemREN_in, dMemWEN_in, Halt_in, dhit;
  word_t pcplus4_in, aluOut_in, rdat2_in, dmemload;
  regbits_t wsel_in;
  logic dmemREN, dmemWEN, mem_stall, wb_valid, wb_WEN, halt;
  word_t dmemaddr, dmemstore, wb_wdat;
  regbits_t wb_wsel;
  logic [CNT_W-1:0] stall_cycles;

  mem_access_stage dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .pcplus4_in(pcplus4_in),
    .aluOut_in(aluOut_in), .rdat2_in(rdat2_in), .wsel_in(wsel_in),
    .MemToReg_in(MemToReg_in), .JType_in(JType_in), .regWEN_in(regWEN_in),
    .dMemREN_in(dMemREN_in), .dMemWEN_in(dMemWEN_in), .Halt_in(Halt_in),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_WEN(wb_WEN),
    .halt(halt), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int nrst, valid;
    logic [31:0] pc, alu, rd2;
    int wsel, m2r, jt, rwen, ren, wen, hlt, dhit;
    logic [31:0] load;
    int e_ren, e_wen, e_stall, e_wbv, e_wsel;
    logic [31:0] e_wdat;
    int e_wbwen, e_halt, e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input vec_t v);
    nRST        = (v.nrst != 0);
    in_valid    = (v.valid != 0);
    pcplus4_in  = v.pc;
    aluOut_in   = v.alu;
    rdat2_in    = v.rd2;
    wsel_in     = 5'(v.wsel);
    MemToReg_in = (v.m2r != 0);
    JType_in    = (v.jt != 0);
    regWEN_in   = (v.rwen != 0);
    dMemREN_in  = (v.ren != 0);
    dMemWEN_in  = (v.wen != 0);
    Halt_in     = (v.hlt != 0);
    dhit        = (v.dhit != 0);
    dmemload    = v.load;
  endtask

  // Reference model: a pending access needs no explicit state because upstream
  // re-presents it every cycle; only halt, the WB slot and the stall count persist.
  bit          m_halted, m_wbv, m_wbwen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;
  int          m_cnt;

  task automatic rcycle(input int i);
    bit memop, e_ren, e_wen, e_stall, commit;
    #1;
    memop   = nRST && !m_halted && in_valid && (dMemREN_in || dMemWEN_in);
    e_wen   = memop && dMemWEN_in;
    e_ren   = memop && dMemREN_in && !dMemWEN_in;
    e_stall = memop && !dhit;
    commit  = nRST && !m_halted && in_valid && (!(dMemREN_in || dMemWEN_in) || dhit);
    chk($sformatf("r%0d dmemREN", i), 32'(dmemREN), 32'(e_ren));
    chk($sformatf("r%0d dmemWEN", i), 32'(dmemWEN), 32'(e_wen));
    chk($sformatf("r%0d mem_stall", i), 32'(mem_stall), 32'(e_stall));
    chk($sformatf("r%0d dmemaddr", i), dmemaddr, aluOut_in);
    @(posedge CLK);
    if (!nRST) begin
      m_halted = 0; m_cnt = 0; m_wbv = 0; m_wbwen = 0; m_wsel = '0; m_wdat = '0;
    end else begin
      if (commit) begin
        m_wbv   = 1;
        m_wbwen = regWEN_in;
        m_wsel  = wsel_in;
        if (MemToReg_in)   m_wdat = dmemload;
        else if (JType_in) m_wdat = pcplus4_in;
        else               m_wdat = aluOut_in;
        if (Halt_in) m_halted = 1;
      end else begin
        m_wbv = 0; m_wbwen = 0;
      end
      if (e_stall && m_cnt < 65535) m_cnt++;
    end
    @(negedge CLK);
    chk($sformatf("r%0d wb_valid", i), 32'(wb_valid), 32'(m_wbv));
    chk($sformatf("r%0d wb_WEN", i), 32'(wb_WEN), 32'(m_wbwen));
    chk($sformatf("r%0d halt", i), 32'(halt), 32'(m_halted));
    chk($sformatf("r%0d stall_cycles", i), 32'(stall_cycles), 32'(m_cnt));
    if (m_wbv) begin
      chk($sformatf("r%0d wb_wsel", i), 32'(wb_wsel), 32'(m_wsel));
      chk($sformatf("r%0d wb_wdat", i), wb_wdat, m_wdat);
    end
  endtask

  initial begin
    vec_t v;
    bit hold;
    logic [31:0] z;
    z = 32'h0;
    v = '{0,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,0,0};
    drive(v);

    tbl.push_back('{0,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,0,0});
    tbl.push_back('{1,1,z,32'h10,z,3,0,0,1,0,0,0,0,z, 0,0,0,1,3,32'h10,1,0,0});
    for (int k = 1; k <= 3; k++)
      tbl.push_back('{1,1,z,32'h40,z,5,1,0,1,1,0,0,0,z, 1,0,1,0,0,z,0,0,k});
    tbl.push_back('{1,1,z,32'h40,z,5,1,0,1,1,0,0,1,32'hDEADBEEF, 1,0,0,1,5,32'hDEADBEEF,1,0,3});
    tbl.push_back('{1,1,z,32'h80,32'h1234,0,0,0,0,0,1,0,1,z, 0,1,0,1,0,32'h80,0,0,3});
    tbl.push_back('{1,1,32'h104,32'h999,z,31,0,1,1,0,0,0,0,z, 0,0,0,1,31,32'h104,1,0,3});
    tbl.push_back('{1,1,z,z,z,0,0,0,0,0,0,1,0,z, 0,0,0,1,0,z,0,1,3});
    tbl.push_back('{1,1,z,32'h40,z,2,0,0,1,1,0,0,0,z, 0,0,0,0,0,z,0,1,3});
    tbl.push_back('{1,1,z,32'h20,z,2,0,0,1,0,0,0,0,z, 0,0,0,0,0,z,0,1,3});
    tbl.push_back('{0,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,0,0});
    tbl.push_back('{1,1,z,32'h44,z,6,1,0,1,1,0,0,0,z, 1,0,1,0,0,z,0,0,1});
    tbl.push_back('{0,1,z,32'h44,z,6,1,0,1,1,0,0,0,z, 0,0,0,0,0,z,0,0,0});
    tbl.push_back('{1,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,0,0});
    tbl.push_back('{1,1,32'h500,32'h48,z,7,1,1,1,1,0,0,1,32'hCAFEF00D, 1,0,0,1,7,32'hCAFEF00D,1,0,0});
    tbl.push_back('{1,1,z,32'h4C,z,8,1,0,1,1,0,1,0,z, 1,0,1,0,0,z,0,0,1});
    tbl.push_back('{1,1,z,32'h4C,z,8,1,0,1,1,0,1,1,32'h77, 1,0,0,1,8,32'h77,1,1,1});
    tbl.push_back('{1,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,1,1});

    @(negedge CLK);
    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v);
      #1;
      chk($sformatf("v%0d dmemREN", i), 32'(dmemREN), v.e_ren);
      chk($sformatf("v%0d dmemWEN", i), 32'(dmemWEN), v.e_wen);
      chk($sformatf("v%0d mem_stall", i), 32'(mem_stall), v.e_stall);
      chk($sformatf("v%0d dmemaddr", i), dmemaddr, v.alu);
      chk($sformatf("v%0d dmemstore", i), dmemstore, v.rd2);
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), v.e_wbv);
      chk($sformatf("v%0d wb_WEN", i), 32'(wb_WEN), v.e_wbwen);
      chk($sformatf("v%0d halt", i), 32'(halt), v.e_halt);
      chk($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), v.e_cnt);
      if (v.e_wbv != 0 || v.nrst == 0) begin
        chk($sformatf("v%0d wb_wsel", i), 32'(wb_wsel), v.e_wsel);
        chk($sformatf("v%0d wb_wdat", i), wb_wdat, v.e_wdat);
      end
    end

    m_halted = 0; m_cnt = 0; m_wbv = 0; m_wbwen = 0; m_wsel = '0; m_wdat = '0;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        int kind;
        nRST        = (i != 0) && ($urandom_range(0, 49) != 0);
        in_valid    = ($urandom_range(0, 5) != 0);
        pcplus4_in  = $urandom;
        aluOut_in   = $urandom;
        rdat2_in    = $urandom;
        wsel_in     = 5'($urandom_range(0, 31));
        MemToReg_in = 1'($urandom_range(0, 1));
        JType_in    = 1'($urandom_range(0, 1));
        regWEN_in   = 1'($urandom_range(0, 1));
        kind        = $urandom_range(0, 2);
        dMemREN_in  = (kind == 1);
        dMemWEN_in  = (kind == 2);
        Halt_in     = ($urandom_range(0, 39) == 0);
      end else begin
        nRST = ($urandom_range(0, 29) != 0);
      end
      dhit     = ($urandom_range(0, 2) == 0);
      dmemload = $urandom;
      hold = nRST && !m_halted && in_valid && (dMemREN_in || dMemWEN_in) && !dhit;
      rcycle(i);
    end

    v = '{0,0,z,z,z,0,0,0,0,0,0,0,0,z, 0,0,0,0,0,z,0,0,0};
    drive(v);
    @(posedge CLK);
    @(negedge CLK);
    v = '{1,1,z,32'h90,z,4,1,0,1,1,0,0,0,z, 0,0,0,0,0,z,0,0,0};
    drive(v);
    repeat (65534) @(posedge CLK);
    @(negedge CLK);
    chk("sat mem_stall", 32'(mem_stall), 32'h1);
    chk("sat near-max", 32'(stall_cycles), 32'hFFFE);
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    chk("sat held", 32'(stall_cycles), 32'hFFFF);
    dhit     = 1'b1;
    dmemload = 32'h5A5A;
    @(posedge CLK);
    @(negedge CLK);
    chk("sat after dhit", 32'(stall_cycles), 32'hFFFF);
    chk("sat commit valid", 32'(wb_valid), 32'h1);
    chk("sat commit wdat", wb_wdat, 32'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
